// File: rtl/mousetrap_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mousetrap_pkg
//   Shared definitions for the MouseTrap injection arbiter:
//   - state_e        : injection FSM states (fixed legacy encoding)
//   - SYNC_STAGES_DEF: default depth of the OutAck synchronizer
//   - flit_at()      : extract flit idx from a packed, zero-extended ReqData bus
// -----------------------------------------------------------------------------
package mousetrap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Upper bounds for the flit helper; callers zero-extend their bus to
    // FLIT_BUS_MAX bits and truncate the result to their own flit width.
    localparam int unsigned MAX_REQ        = 8;
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned FLIT_BUS_MAX   = MAX_REQ * MAX_DATA_WIDTH;

    function automatic logic [MAX_DATA_WIDTH-1:0] flit_at(
        input logic [FLIT_BUS_MAX-1:0] bus,
        input int unsigned             idx,
        input int unsigned             width
    );
        logic [FLIT_BUS_MAX-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[MAX_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr_i and wraps
//   modulo NUM_REQ; the first requesting index wins. The pointer register
//   lives in the instantiating module.
//   req_i   : request vector
//   ptr_i   : index where the search starts
//   grant_o : one-hot grant (all zero when no request)
//   any_o   : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mousetrap_inject_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mousetrap_inject_arbiter
//   Shares one MouseTrap pipeline input channel among NUM_REQ clocked
//   requesters. Round-robin grant, registered flit, 2-phase OutReq/OutAck
//   handshake toward the first latch stage.
//   Clock    : sole clock
//   Reset    : async active-high, same net as the pipeline latch clear
//   ReqValid : per-requester flit pending (held until accepted)
//   ReqData  : packed flits, flit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ReqReady : one-hot, one-cycle accept pulse
//   OutData  : bundled data to pipeline stage 0 (registered)
//   OutReq   : 2-phase request, toggles once per flit (registered)
//   OutAck   : 2-phase ack from stage 0, asynchronous to Clock
//   Busy     : transfer in flight (state != IDLE)
//   ProtoErr : sticky, ack phase changed with no outstanding request
// -----------------------------------------------------------------------------
module mousetrap_inject_arbiter
    import mousetrap_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            ReqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
    output logic [NUM_REQ-1:0]            ReqReady,
    output logic [DATA_WIDTH-1:0]         OutData,
    output logic                          OutReq,
    input  logic                          OutAck,
    output logic                          Busy,
    output logic                          ProtoErr
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    req_q, req_d;
    logic                    err_q, err_d;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;

    logic                    ack_sync;
    logic                    ack_edge;
    logic [NUM_REQ-1:0]      grant;
    logic                    any_req;
    logic [PTR_W-1:0]        win_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_req)
    );

    // OutAck synchronizer; cleared together with the pipeline latches.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], OutAck};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    // AckSync will change on the coming edge; flagging it now makes ProtoErr
    // rise on the same edge that AckSync itself changes.
    assign ack_edge = ack_sync_q[SYNC_STAGES-1] ^ ack_sync_q[SYNC_STAGES-2];

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        data_d  = data_q;
        req_d   = req_q;
        err_d   = err_q | (ack_edge && (state_q != ST_WAIT));
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    ready_d = grant;
                    data_d  = DATA_WIDTH'(flit_at(FLIT_BUS_MAX'(ReqData),
                                                  32'(win_idx), DATA_WIDTH));
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                               : win_idx + PTR_W'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Data has been on OutData for a full cycle before this toggle.
                req_d   = ~req_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_sync == req_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ready_q <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    assign ReqReady = ready_q;
    assign OutData  = data_q;
    assign OutReq   = req_q;
    assign Busy     = (state_q != ST_IDLE);
    assign ProtoErr = err_q;

endmodule

// File: tb/tb_mousetrap_inject_arbiter.sv
`timescale 1ns/1ps
module tb_mousetrap_inject_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned SS   = 2;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [NREQ-1:0]      ReqValid;
    logic [NREQ*DW-1:0]   ReqData;
    logic [NREQ-1:0]      ReqReady;
    logic [DW-1:0]        OutData;
    logic                 OutReq;
    logic                 OutAck;
    logic                 Busy;
    logic                 ProtoErr;

    logic        ack_model = 1'b0;
    logic        ack_flip  = 1'b0;
    logic        ack_auto  = 1'b1;
    int unsigned ack_dly   = 7;

    int n_checks = 0;
    int n_fail   = 0;

    assign OutAck = ack_model ^ ack_flip;

    mousetrap_inject_arbiter #(
        .NUM_REQ     (NREQ),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqData  (ReqData),
        .ReqReady (ReqReady),
        .OutData  (OutData),
        .OutReq   (OutReq),
        .OutAck   (OutAck),
        .Busy     (Busy),
        .ProtoErr (ProtoErr)
    );

    always #5 Clock = ~Clock;

    // Stage-0 model: echoes each OutReq phase after ack_dly; its latches
    // clear on Reset like the real pipeline.
    always begin
        @(OutReq or posedge Reset);
        if (Reset) begin
            ack_model = 1'b0;
        end else if (ack_auto) begin
            #(ack_dly);
            ack_model = OutReq;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (ReqReady != '0) begin
                cyc = c;
                for (int i = 0; i < NREQ; i++) if (ReqReady[i]) idx = i;
                break;
            end
        end
        if (idx < 0) check_eq({tag, " grant timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (Busy == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq({tag, " idle timeout"}, 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset    = 1'b1;
        ack_flip = 1'b0;
        ReqValid = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;
        int counts [NREQ];
        int sparse_exp [3];

        Reset    = 1'b1;
        ReqValid = '0;
        ReqData  = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            check_eq("idle OutReq",   64'(OutReq),   64'(0));
            check_eq("idle OutData",  64'(OutData),  64'(0));
            check_eq("idle Busy",     64'(Busy),     64'(0));
            check_eq("idle ProtoErr", 64'(ProtoErr), 64'(0));
            check_eq("idle ReqReady", 64'(ReqReady), 64'(0));
        end

        // Single flit, then a second flit from the same lane
        ReqData[31:0] = 32'hDEADBEEF;
        ReqValid      = 4'b0001;
        @(negedge Clock);
        check_eq("single ReqReady", 64'(ReqReady), 64'(4'b0001));
        check_eq("single OutData",  64'(OutData),  64'(32'hDEADBEEF));
        check_eq("single OutReq@n", 64'(OutReq),   64'(0));
        check_eq("single Busy",     64'(Busy),     64'(1));
        ReqData[31:0] = 32'h12345678;
        @(negedge Clock);
        check_eq("single ReqReady@n+1", 64'(ReqReady), 64'(0));
        check_eq("single OutReq@n+1",   64'(OutReq),   64'(1));
        check_eq("single OutData hold", 64'(OutData),  64'(32'hDEADBEEF));
        wait_grant("single next", idx, cyc);
        check_eq("single ack->grant cycles", 64'(cyc), 64'(SS + 2));
        check_eq("single next idx",     64'(idx),     64'(0));
        check_eq("single next OutData", 64'(OutData), 64'(32'h12345678));
        ReqValid = '0;
        @(negedge Clock);
        check_eq("single second toggle", 64'(OutReq), 64'(0));
        wait_idle("single");

        // Fairness: all lanes valid continuously, ack echoed after ~1 cycle
        do_reset();
        ack_dly = 9;
        for (int i = 0; i < NREQ; i++) begin
            counts[i] = 0;
            ReqData[i*DW +: DW] = DW'(32'hA0 + i);
        end
        ReqValid = 4'b1111;
        for (int g = 0; g < 40; g++) begin
            wait_grant("fair", idx, cyc);
            check_eq("fair order",   64'(idx),               64'(g % 4));
            check_eq("fair onehot",  64'($onehot(ReqReady)), 64'(1));
            check_eq("fair OutData", 64'(OutData),           64'(32'hA0 + (g % 4)));
            if (idx >= 0) counts[idx]++;
        end
        ReqValid = '0;
        for (int i = 0; i < NREQ; i++) check_eq("fair count", 64'(counts[i]), 64'(10));
        wait_idle("fair");

        // Sparse wrap: move pointer to 3, then lanes 0 and 2 alternate
        ack_dly  = 7;
        ReqValid = 4'b0100;
        wait_grant("sparse setup", idx, cyc);
        check_eq("sparse setup idx", 64'(idx), 64'(2));
        ReqValid = '0;
        wait_idle("sparse setup");
        sparse_exp = '{0, 2, 0};
        ReqValid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            wait_grant("sparse", idx, cyc);
            check_eq("sparse idx", 64'(idx), 64'(sparse_exp[k]));
        end
        ReqValid = '0;
        wait_idle("sparse");

        // Protocol error: ack phase flips while idle
        ack_auto = 1'b0;
        repeat (3) @(negedge Clock);
        ack_flip = 1'b1;
        @(negedge Clock);
        check_eq("proto before sync", 64'(ProtoErr), 64'(0));
        @(negedge Clock);
        check_eq("proto set",  64'(ProtoErr), 64'(1));
        check_eq("proto idle", 64'(Busy),     64'(0));
        repeat (5) @(negedge Clock);
        check_eq("proto sticky",     64'(ProtoErr), 64'(1));
        check_eq("proto still idle", 64'(Busy),     64'(0));

        // Reset in WAIT
        do_reset();
        check_eq("proto cleared by reset", 64'(ProtoErr), 64'(0));
        ReqData[31:0] = 32'hCAFEF00D;
        ReqValid      = 4'b0001;
        wait_grant("rst-wait", idx, cyc);
        check_eq("rst-wait idx", 64'(idx), 64'(0));
        ReqValid = '0;
        @(negedge Clock);
        check_eq("rst-wait OutReq", 64'(OutReq), 64'(1));
        @(negedge Clock);
        check_eq("rst-wait Busy", 64'(Busy), 64'(1));
        #2;
        Reset = 1'b1;
        #1;
        check_eq("rst-wait async OutReq",   64'(OutReq),   64'(0));
        check_eq("rst-wait async OutData",  64'(OutData),  64'(0));
        check_eq("rst-wait async ReqReady", 64'(ReqReady), 64'(0));
        check_eq("rst-wait async Busy",     64'(Busy),     64'(0));
        check_eq("rst-wait async ProtoErr", 64'(ProtoErr), 64'(0));
        @(negedge Clock);
        Reset    = 1'b0;
        ack_auto = 1'b1;
        @(negedge Clock);
        ReqData[31:0] = 32'h0BADCAFE;
        ReqValid      = 4'b0001;
        wait_grant("post-rst", idx, cyc);
        check_eq("post-rst idx",    64'(idx),    64'(0));
        check_eq("post-rst OutReq", 64'(OutReq), 64'(0));
        ReqValid = '0;
        @(negedge Clock);
        check_eq("post-rst OutReq toggle", 64'(OutReq),  64'(1));
        check_eq("post-rst OutData",       64'(OutData), 64'(32'h0BADCAFE));
        wait_idle("post-rst");
        repeat (4) @(negedge Clock);
        check_eq("post-rst ProtoErr", 64'(ProtoErr), 64'(0));
        check_eq("post-rst Busy",     64'(Busy),     64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mousetrap_inject_arbiter.md
# mousetrap_inject_arbiter

Clocked injection controller that shares one MouseTrap asynchronous pipeline input channel among NUM_REQ synchronous requesters. It arbitrates round-robin, registers the winning flit, and drives the pipeline's 2-phase bundled-data handshake (OutReq/OutAck), so the first latch stage is only ever opened on stable data. It sits at the clocked edge of each NoC router port, feeding the first `latchDir` stage.

## Interface
- NUM_REQ, 4, number of clocked requesters (2..8)
- DATA_WIDTH, 32, flit width
- SYNC_STAGES, 2, flops in the OutAck synchronizer (≥2)

- Clock  in  1  sole clock
- Reset  in  1  asynchronous, active-high reset; same net as the pipeline latch `Reset` (CLR)
- ReqValid  in  NUM_REQ  requester i has a flit pending; held until accepted
- ReqData  in  NUM_REQ*DATA_WIDTH  flit i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- ReqReady  out  NUM_REQ  one-hot, one-cycle accept pulse; flit i is consumed that cycle
- OutData  out  DATA_WIDTH  bundled data to pipeline stage 0
- OutReq  out  1  2-phase request; a toggle means new data
- OutAck  in  1  2-phase ack from stage 0, asynchronous to Clock
- Busy  out  1  a transfer is in flight (state ≠ IDLE)
- ProtoErr  out  1  sticky; OutAck toggled with no outstanding request

## Operation
- States: IDLE, LAUNCH, WAIT.
- IDLE: if any ReqValid, grant winner w, pulse ReqReady[w], load OutData ← ReqData[w], advance pointer to w+1 mod NUM_REQ, go to LAUNCH. If no ReqValid, stay in IDLE with no outputs changed.
- LAUNCH: toggle OutReq, go to WAIT. Data has been stable for at least one cycle before the toggle; this is the bundled-data setup margin.
- WAIT: when AckSync == OutReq, go to IDLE. OutData holds throughout WAIT.
- Round-robin: search starts at the pointer and wraps modulo NUM_REQ. A lone requester is granted on every slot. The pointer changes only on a grant.
- AckSync is OutAck passed through SYNC_STAGES flops, all cleared by Reset.
- ProtoErr is set when AckSync changes while in IDLE or LAUNCH. It clears only on Reset. The FSM ignores the spurious edge.
- Reset values (asynchronous): state = IDLE, OutReq = 0, OutData = 0, ReqReady = 0, Busy = 0, ProtoErr = 0, pointer = 0, sync flops = 0.
- Reset mid-transfer: the in-flight flit is dropped. Phases realign because the pipeline latches clear on the same Reset. Requesters must re-present ReqValid.

## Timing
- Grant to OutReq toggle: 1 cycle (cycle n ReqReady, cycle n+1 OutReq toggles).
- OutAck toggle to next grant: SYNC_STAGES cycles + 1 (WAIT→IDLE) + 1 (IDLE grant).
- Minimum slot with ack returning instantly: 3 + SYNC_STAGES cycles per flit.
- ReqReady is asserted only in IDLE, at most one bit, never two cycles in a row.
- ReqValid dropped before the grant is legal; no grant is issued for it.
- Simultaneous valids: the lowest index at or after the pointer wins.
- OutReq and OutData are registered outputs with no combinational path from inputs.

## Structure
- Shared package `mousetrap_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT),
  - the SYNC_STAGES default,
  - a helper to extract flit i from the packed ReqData.
- One sub-module, `rr_arbiter`:
  - parameter NUM_REQ; inputs req, ptr; outputs one-hot grant and any.
  - Purely combinational; the pointer register stays in the top.
- The synchronizer is inline (shift register), with an ASYNC_REG attribute on its flops.

## Test plan
- Reset, then ReqValid = 0: OutReq = 0, OutData = 0, Busy = 0, ProtoErr = 0 for 20 cycles.
- Single flit: ReqValid = 4'b0001, ReqData[0] = 32'hDEADBEEF.
  - ReqReady[0] pulses at cycle n and OutData = DEADBEEF at n+1.
  - OutReq goes 0→1 at n+1.
  - Ack model returns the toggle after 7 ns; next grant follows SYNC_STAGES+2 cycles after the ack.
- Fairness: all four valid continuously, ack echoed after 1 cycle; over 40 grants the order is 0,1,2,3,0,… and each index gets exactly 10.
- Sparse wrap: pointer at 3, ReqValid = 4'b0101 → grant 0, then 2, then 0.
- Protocol error: toggle OutAck while in IDLE → ProtoErr = 1 on the cycle AckSync changes, state stays IDLE, and ProtoErr holds until Reset.
- Reset in WAIT: assert Reset mid-transfer with OutReq = 1 → all outputs return to reset values immediately. After release, one flit completes with OutReq 0→1 and no ProtoErr.
